// File: rtl/aes_round_sched.sv
// AES round scheduler: sequences AddRoundKey / SubShift / MixColumn phase
// enables for one block, with stale-done filtering, a one-cycle gap between
// phases, a per-phase timeout and abort handling.
module aes_round_sched #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       add_done,
  input  logic       ss_done,
  input  logic       mc_done,
  output logic       add_en,
  output logic       ss_en,
  output logic       mc_en,
  output logic [1:0] src_sel,
  output logic [3:0] key_round,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    IDLE, ARK0, SS, MC, ARK, ARKF, GAP, FIN, ERR
  } state_t;

  localparam logic [1:0] SRC_PT = 2'b00;
  localparam logic [1:0] SRC_MC = 2'b01;
  localparam logic [1:0] SRC_SS = 2'b10;
  localparam logic [8:0] TMO    = 9'(TIMEOUT);

  state_t      state_q, state_d;
  state_t      nxt_q, nxt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  kr_q, kr_d;
  logic [1:0]  src_q, src_d;
  logic        add_en_q, add_en_d;
  logic        ss_en_q, ss_en_d;
  logic        mc_en_q, mc_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        ph_act;
  logic        ph_done;
  logic        done_ok;
  logic        tmo;

  // Select the completion flag of the phase currently enabled; a done seen in
  // the first enable cycle (counter still 0) is treated as stale.
  always_comb begin
    ph_act  = 1'b0;
    ph_done = 1'b0;
    case (state_q)
      ARK0, ARK, ARKF: begin ph_act = 1'b1; ph_done = add_done; end
      SS:              begin ph_act = 1'b1; ph_done = ss_done;  end
      MC:              begin ph_act = 1'b1; ph_done = mc_done;  end
      default:         ;
    endcase
    done_ok = ph_act && (cnt_q != 8'd0) && ph_done;
    tmo     = ph_act && (({1'b0, cnt_q} + 9'd1) == TMO);
  end

  // Next-state, round bookkeeping and registered output decode.
  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    cnt_d   = 8'd0;
    kr_d    = kr_q;
    src_d   = src_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ARK0;
          kr_d    = 4'd0;
          src_d   = SRC_PT;
        end
      end
      ARK0, SS, MC, ARK, ARKF: begin
        if (done_ok) begin
          state_d = GAP;
          case (state_q)
            ARK0: begin nxt_d = SS; kr_d = kr_q + 4'd1; end
            ARK:  begin nxt_d = SS; kr_d = kr_q + 4'd1; end
            SS: begin
              if (int'(kr_q) < NR) begin
                nxt_d = MC;
              end else begin
                nxt_d = ARKF;
                src_d = SRC_SS;
              end
            end
            MC:      begin nxt_d = ARK; src_d = SRC_MC; end
            default: nxt_d = FIN;
          endcase
        end else if (tmo) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP:     state_d = nxt_q;
      FIN:     state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    // Abort cancels any activity but leaves the round index visible.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      kr_d    = kr_q;
      src_d   = src_q;
      cnt_d   = 8'd0;
    end

    add_en_d = (state_d == ARK0) || (state_d == ARK) || (state_d == ARKF);
    ss_en_d  = (state_d == SS);
    mc_en_d  = (state_d == MC);
    busy_d   = !((state_d == IDLE) || (state_d == FIN) || (state_d == ERR));
    done_d   = (state_d == FIN);
    err_d    = (state_d == ERR);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      nxt_q    <= IDLE;
      cnt_q    <= 8'd0;
      kr_q     <= 4'd0;
      src_q    <= SRC_PT;
      add_en_q <= 1'b0;
      ss_en_q  <= 1'b0;
      mc_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      nxt_q    <= nxt_d;
      cnt_q    <= cnt_d;
      kr_q     <= kr_d;
      src_q    <= src_d;
      add_en_q <= add_en_d;
      ss_en_q  <= ss_en_d;
      mc_en_q  <= mc_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign add_en    = add_en_q;
  assign ss_en     = ss_en_q;
  assign mc_en     = mc_en_q;
  assign src_sel   = src_q;
  assign key_round = kr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched: a cycle table for the first phases plus
// responder-driven sequences for full run, abort, reset and timeout.
module tb_aes_round_sched;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       add_done, ss_done, mc_done;
  logic       add_en, ss_en, mc_en;
  logic [1:0] src_sel;
  logic [3:0] key_round;
  logic       busy, done, err;

  int errors = 0;
  int checks = 0;
  int onehot_bad = 0;

  logic resp_on = 1'b0;
  logic withhold_mc = 1'b0;
  logic p_add = 1'b0, p_ss = 1'b0, p_mc = 1'b0;

  aes_round_sched #(.NR(10), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .add_done(add_done), .ss_done(ss_done), .mc_done(mc_done),
    .add_en(add_en), .ss_en(ss_en), .mc_en(mc_en),
    .src_sel(src_sel), .key_round(key_round),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, start, abort, ad, sd, md;
    logic [11:0] exp;   // {add_en, ss_en, mc_en, src_sel, key_round, busy, done, err}
  } vec_t;

  vec_t tbl [0:20];

  function automatic logic [11:0] outv();
    return {add_en, ss_en, mc_en, src_sel, key_round, busy, done, err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: sample outputs after the edge, then let the responder answer.
  task automatic tick();
    @(posedge clk);
    #1;
    if (int'(add_en) + int'(ss_en) + int'(mc_en) > 1) onehot_bad++;
    if (resp_on) begin
      add_done = add_en && p_add;
      ss_done  = ss_en && p_ss;
      mc_done  = withhold_mc ? 1'b0 : (mc_en && p_mc);
    end
    p_add = add_en;
    p_ss  = ss_en;
    p_mc  = mc_en;
  endtask

  initial begin
    int n, adds, sss, mcs, done_at, kr_bad, exp_kr, cnt;
    logic [1:0] final_src;
    logic l_add, l_ss, l_mc;

    rst = 1'b0; start = 1'b0; abort = 1'b0;
    add_done = 1'b0; ss_done = 1'b0; mc_done = 1'b0;

    tbl[0]  = {6'b010000, 12'b000_00_0000_000};
    tbl[1]  = {6'b111000, 12'b000_00_0000_000};
    tbl[2]  = {6'b110000, 12'b100_00_0000_100};
    tbl[3]  = {6'b100100, 12'b100_00_0000_100};
    tbl[4]  = {6'b100000, 12'b100_00_0000_100};
    tbl[5]  = {6'b100100, 12'b000_00_0001_100};
    tbl[6]  = {6'b100110, 12'b010_00_0001_100};
    tbl[7]  = {6'b100010, 12'b010_00_0001_100};
    tbl[8]  = {6'b100101, 12'b010_00_0001_100};
    tbl[9]  = {6'b100010, 12'b000_00_0001_100};
    tbl[10] = {6'b100000, 12'b001_00_0001_100};
    tbl[11] = {6'b100001, 12'b001_00_0001_100};
    tbl[12] = {6'b100001, 12'b000_01_0001_100};
    tbl[13] = {6'b100000, 12'b100_01_0001_100};
    tbl[14] = {6'b100100, 12'b100_01_0001_100};
    tbl[15] = {6'b101000, 12'b000_01_0001_000};
    tbl[16] = {6'b110000, 12'b100_00_0000_100};
    tbl[17] = {6'b010000, 12'b000_00_0000_000};
    tbl[18] = {6'b100000, 12'b000_00_0000_000};
    tbl[19] = {6'b110000, 12'b100_00_0000_100};
    tbl[20] = {6'b111000, 12'b000_00_0000_000};

    tick();
    for (int i = 0; i <= 20; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort;
      add_done = tbl[i].ad; ss_done = tbl[i].sd; mc_done = tbl[i].md;
      tick();
      chk($sformatf("row%0d", i), 32'(outv()), 32'(tbl[i].exp));
    end
    start = 1'b0; abort = 1'b0;
    add_done = 1'b0; ss_done = 1'b0; mc_done = 1'b0;
    tick();

    // Nominal full block with the one-cycle-late responder.
    resp_on = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    n = 0; adds = 0; sss = 0; mcs = 0; done_at = -1; kr_bad = 0; exp_kr = 0;
    final_src = 2'b11; l_add = 1'b0; l_ss = 1'b0; l_mc = 1'b1;
    l_mc = 1'b0;
    while (n < 200 && done_at < 0) begin
      tick(); n++;
      if (add_en && !l_add) begin
        adds++;
        if (int'(key_round) != exp_kr) kr_bad++;
        exp_kr++;
        final_src = src_sel;
      end
      if (ss_en && !l_ss) sss++;
      if (mc_en && !l_mc) mcs++;
      if (done) done_at = n;
      l_add = add_en; l_ss = ss_en; l_mc = mc_en;
    end
    chk("add_pulses", 32'(adds), 32'd11);
    chk("ss_pulses", 32'(sss), 32'd10);
    chk("mc_pulses", 32'(mcs), 32'd9);
    chk("done_latency", 32'(done_at), 32'd90);
    chk("key_seq_bad", 32'(kr_bad), 32'd0);
    chk("final_src_sel", 32'(final_src), 32'd2);
    chk("fin_busy", 32'(busy), 32'd0);
    tick();
    chk("post_done_pulse", 32'({done, busy}), 32'd0);
    chk("kr_hold_idle", 32'(key_round), 32'd10);

    // Abort during SubShift of round 5, then restart.
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (n < 200 && !(ss_en && key_round == 4'd5)) begin tick(); n++; end
    chk("reach_ss5", 32'(ss_en && key_round == 4'd5), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_out", 32'(outv()), 32'({3'b000, src_sel, 4'd5, 3'b000}));
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (done || busy) cnt++; end
    chk("abort_no_done", 32'(cnt), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart", 32'(outv()), 32'(12'b100_00_0000_100));

    // Reset during ARK of round 3; start while in reset is ignored.
    n = 0;
    while (n < 200 && !(add_en && key_round == 4'd3 && src_sel == 2'b01)) begin tick(); n++; end
    chk("reach_ark3", 32'(add_en && key_round == 4'd3 && src_sel == 2'b01), 32'd1);
    rst = 1'b0; start = 1'b1;
    tick();
    chk("midrun_rst", 32'(outv()), 32'd0);
    tick();
    chk("rst_blocks_start", 32'(outv()), 32'd0);
    rst = 1'b1; start = 1'b0;
    add_done = 1'b0; ss_done = 1'b0; mc_done = 1'b0;
    tick();

    // Timeout: MixColumn never completes.
    withhold_mc = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    n = 0; cnt = 0;
    while (n < 600 && !err) begin tick(); n++; if (mc_en) cnt++; end
    chk("mc_en_cycles", 32'(cnt), 32'd255);
    chk("err_state", 32'({add_en, ss_en, mc_en, busy, done, err}), 32'b000001);
    tick();
    chk("err_sticky", 32'({busy, err}), 32'b01);
    abort = 1'b1; tick(); abort = 1'b0;
    withhold_mc = 1'b0;
    chk("err_abort", 32'({add_en, ss_en, mc_en, busy, done, err}), 32'd0);

    chk("onehot_viol", 32'(onehot_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_round_sched.md
AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of AES rounds (the final round skips MixColumns).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles a phase enable may stay high without its done (8-bit).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1, begin one block encryption; sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1, cancel the current encryption.
REQ-007 SHALL have ports add_done, ss_done and mc_done, each input, 1, the AddRoundKey, SubShift and MixColumn completion flags.
REQ-008 SHALL have ports add_en, ss_en and mc_en, each output, 1, the registered phase enables to the three datapath units.
REQ-009 SHALL have port src_sel, output, 2, the AddRoundKey state source: 00 plaintext, 01 mix_columns output, 10 sub_shift output, 11 unused.
REQ-010 SHALL have port key_round, output, 4, the round-key index for the current AddRoundKey (0..NR).
REQ-011 SHALL have ports busy, output, 1, high from the cycle after start acceptance until done or abort; done, output, 1, a one-cycle completion pulse; and err, output, 1, a sticky timeout flag.

Function
REQ-012 SHALL implement states IDLE, ARK0, SS, MC, ARK, ARKF, GAP, FIN and ERR.
REQ-013 SHALL keep at most one of add_en, ss_en and mc_en high in any cycle.
REQ-014 SHALL assert the phase enable in the first cycle of the phase state and hold it until the matching done is sampled.
REQ-015 SHALL sample a done flag only from the second cycle of its enable onward, so a done already present in the enable's first cycle is ignored as stale.
REQ-016 SHALL, when done is sampled, drop the enable the next cycle, spend exactly one GAP cycle with all enables low, then enter the next phase.
REQ-017 SHALL make the minimum phase length 3 cycles: 2 enable cycles plus 1 gap.
REQ-018 SHALL, on IDLE with start=1 and abort=0, go to ARK0 with src_sel=00, key_round=0, busy=1, and add_en high the next cycle.
REQ-019 SHALL, on ARK0 done, increment key_round to 1 and go to SS.
REQ-020 SHALL, on SS done, go to MC if key_round<NR; otherwise go to ARKF with src_sel=10.
REQ-021 SHALL, on MC done, go to ARK with src_sel=01.
REQ-022 SHALL, on ARK done, increment key_round and go to SS.
REQ-023 SHALL, on ARKF done, go to FIN, which asserts done=1 and busy=0 for one cycle and then returns to IDLE.
REQ-024 SHALL hold key_round at its last value in IDLE after completion and clear it to 0 on the next start.
REQ-025 SHALL keep src_sel stable for the entire add_en high interval.
REQ-026 SHALL run an 8-bit phase counter that clears on each phase entry and counts while an enable is high.
REQ-027 SHALL, when the phase counter reaches TIMEOUT without done, go to ERR with all enables low, err=1, busy=0 and no done.
REQ-028 SHALL, when done and timeout occur in the same cycle, let done win.
REQ-029 SHALL, when abort=1 in any non-IDLE state, go to IDLE the next cycle with enables low, busy=0, done=0 and key_round unchanged.
REQ-030 SHALL, when abort and start are both high in IDLE, stay in IDLE.
REQ-031 SHALL hold ERR until abort; abort clears err and returns to IDLE.
REQ-032 SHALL ignore start in every state except IDLE.
REQ-033 SHALL ignore done flags from the phases not currently enabled.
REQ-034 SHALL produce 2*NR+NR-1+1 phases per block, i.e. 30 phases for NR=10: add_en pulses NR+1, ss_en pulses NR, mc_en pulses NR-1.

Reset
REQ-035 SHALL, while rst=0 at a clock edge, force the state to IDLE, key_round=0, src_sel=00, all enables=0, busy=0, done=0, err=0 and the phase counter=0.
REQ-036 SHALL apply REQ-035 even mid-phase, overriding abort and start.

Verification
REQ-037 SHALL cover a nominal run: NR=10 with a responder raising each done 1 cycle after its enable's first cycle gives add_en/ss_en/mc_en counts 11/10/9, done high exactly 90 cycles after start acceptance, and key_round sequence 0..10.
REQ-038 SHALL cover the last round: after the 10th ss_done, the next enable is add_en with src_sel=10, and mc_en never rises.
REQ-039 SHALL cover a stale done: ss_done held high from before ss_en rises has no effect until ss_en's second cycle, and no phase is skipped.
REQ-040 SHALL cover timeout: mc_done withheld for 255 enable cycles gives ERR with err=1 and enables low; then abort gives err=0 and IDLE.
REQ-041 SHALL cover abort mid-round: abort during SS of round 5 gives IDLE next cycle, key_round=5, and no done; a following start restarts at key_round=0.
REQ-042 SHALL cover mid-run reset: rst=0 during ARK of round 3 gives all outputs at reset values the next cycle, and start in IDLE is ignored while rst=0.
